// File: rtl/reset_ctrl_pkg.sv
// Shared types for the reset controller: reset cause codes and sequencer states.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package reset_ctrl_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_BTN = 2'd1,
    CAUSE_SW  = 2'd2
  } reset_cause_t;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_t;

  // Elaboration-time helper for sizing the shared hold/stagger counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_ctrl_if.sv
// Bundles the reset request inputs and the reset domain/status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface reset_ctrl_if
  import reset_ctrl_pkg::*;
#(
  parameter int NUM_OUTPUTS = 2
);

  logic                   btn_i;
  logic                   sw_reset_i;
  logic [NUM_OUTPUTS-1:0] reset_o;
  reset_cause_t           reset_cause_o;
  logic                   busy_o;

  // Board/SoC side: drives the requests, observes the resets.
  modport master (
    output btn_i,
    output sw_reset_i,
    input  reset_o,
    input  reset_cause_o,
    input  busy_o
  );

  // Controller side.
  modport slave (
    input  btn_i,
    input  sw_reset_i,
    output reset_o,
    output reset_cause_o,
    output busy_o
  );

endinterface

// File: rtl/reset_ctrl_debouncer.sv
// Synchronises a raw push-button and accepts a level change only after it is stable.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clk edges from a clean raw edge to level_o.
// Backpressure: none; level_o is a registered, active-high "pressed" level.
module reset_ctrl_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic          IDLE_RAW = ACTIVE_LOW;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   pressed;

  // Normalise the synchronised pin to active-high "pressed".
  assign pressed = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Metastability chain, cleared to the released pin level.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) sync_q <= {SYNC_STAGES{IDLE_RAW}};
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      level_o <= 1'b0;
    end else if (pressed != level_o) begin
      if (cnt_q == CNT_LAST) begin
        level_o <= pressed;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/reset_ctrl.sv
// System reset controller: merges hard, button and software resets into staggered domain resets.
// Latency: request -> all resets asserted in 1 edge; release POR_CYCLES + k*STAGGER_CYCLES edges after requests end.
// Backpressure: none; any request during HOLD simply restarts the hold count.
module reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int POR_CYCLES      = 31,
  parameter int STAGGER_CYCLES  = 16,
  parameter int NUM_OUTPUTS     = 2,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int SYNC_STAGES     = 2
) (
  input  logic         clk,
  input  logic         reset_i,
  reset_ctrl_if.slave  bus
);

  localparam int                   CW       = $clog2(max_int(POR_CYCLES, STAGGER_CYCLES) + 1);
  localparam int                   IW       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [CW-1:0]        POR_LAST = CW'(POR_CYCLES);
  localparam logic [CW-1:0]        STG_LAST = CW'(STAGGER_CYCLES);
  localparam logic [IW-1:0]        IDX_LAST = IW'(NUM_OUTPUTS - 1);
  localparam logic [NUM_OUTPUTS-1:0] ALL_ON = {NUM_OUTPUTS{1'b1}};

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0] rst_q, rst_d;
  reset_cause_t           cause_q, cause_d;
  logic                   busy_q;
  logic                   btn_level;
  logic                   req;

  reset_ctrl_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (BTN_ACTIVE_LOW)
  ) u_debouncer (
    .clk     (clk),
    .reset_i (reset_i),
    .raw_i   (bus.btn_i),
    .level_o (btn_level)
  );

  assign req     = btn_level | bus.sw_reset_i;
  assign cnt_inc = cnt_q + CW'(1);

  // Sequencer registers; hard reset asserts every domain without a clock.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= ALL_ON;
      cause_q <= CAUSE_POR;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      cause_q <= cause_d;
      busy_q  <= |rst_d;
    end
  end

  // Next-state: hold all domains, then release them one by one; any request restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    cause_d = cause_q;
    case (state_q)
      HOLD: begin
        rst_d = ALL_ON;
        idx_d = '0;
        if (req) begin
          cnt_d = '0;
        end else if (cnt_inc == POR_LAST) begin
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          idx_d    = IW'(1);
          state_d  = (NUM_OUTPUTS == 1) ? RUN : RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE, RUN: begin
        if (req) begin
          // Button is reported in preference to a simultaneous software request.
          rst_d   = ALL_ON;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = HOLD;
          cause_d = btn_level ? CAUSE_BTN : CAUSE_SW;
        end else if (state_q == RUN) begin
          rst_d = '0;
        end else if (cnt_inc == STG_LAST) begin
          rst_d[idx_q] = 1'b0;
          cnt_d        = '0;
          if (idx_q == IDX_LAST) state_d = RUN;
          else                   idx_d   = idx_q + IW'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = HOLD;
        rst_d   = ALL_ON;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.reset_o       = rst_q;
  assign bus.reset_cause_o = cause_q;
  assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: directed scenarios checked against a timing model every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_reset_ctrl;

  localparam int POR = 8;
  localparam int STG = 4;
  localparam int NO  = 3;
  localparam int DEB = 5;
  localparam int SYN = 2;

  logic clk     = 1'b0;
  logic reset_i = 1'b0;

  reset_ctrl_if #(.NUM_OUTPUTS(NO)) bus ();

  reset_ctrl #(
    .POR_CYCLES      (POR),
    .STAGGER_CYCLES  (STG),
    .NUM_OUTPUTS     (NO),
    .DEBOUNCE_CYCLES (DEB),
    .BTN_ACTIVE_LOW  (1'b1),
    .SYNC_STAGES     (SYN)
  ) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: m_t = edges since the last request (or hard reset) with no request.
  // Domain k is held while m_t < POR + k*STG. m_hist holds sampled button presses,
  // newest first, so the debouncer sees m_hist[SYN+j] as its j-th previous input.
  int m_t;
  int m_cause;
  bit m_deb;
  bit m_hist[$];
  bit m_pressed;
  bit m_req;
  bit m_flip;

  task automatic model_clear();
    m_t     = 0;
    m_cause = 0;
    m_deb   = 1'b0;
    m_hist.delete();
    for (int i = 0; i < SYN + DEB; i++) m_hist.push_back(1'b0);
  endtask

  function automatic logic [NO-1:0] exp_rst(input int t);
    logic [NO-1:0] r;
    for (int k = 0; k < NO; k++) r[k] = (t < POR + k * STG);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0b exp=%0b at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      model_clear();
    end else begin
      m_pressed = (bus.btn_i == 1'b0);
      m_req     = m_deb | bus.sw_reset_i;
      if (m_req) begin
        if (m_t >= POR) m_cause = m_deb ? 1 : 2;
        m_t = 0;
      end else if (m_t < 10000) begin
        m_t++;
      end
      m_hist.push_front(m_pressed);
      void'(m_hist.pop_back());
      m_flip = 1'b1;
      for (int j = 0; j < DEB; j++) if (m_hist[SYN + j] == m_deb) m_flip = 1'b0;
      if (m_flip) m_deb = ~m_deb;
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    check("model_reset_o", 32'(bus.reset_o), 32'(exp_rst(m_t)));
    check("model_busy_o", 32'(bus.busy_o), 32'(|exp_rst(m_t)));
    check("model_cause", 32'(bus.reset_cause_o), 32'(m_cause));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic sw_pulse();
    bus.sw_reset_i = 1'b1;
    tick(1);
    bus.sw_reset_i = 1'b0;
  endtask

  initial begin
    model_clear();
    bus.btn_i      = 1'b1;
    bus.sw_reset_i = 1'b0;

    // 1. Power-on, checked before any clock edge.
    #1 reset_i = 1'b1;
    #1;
    check("por_async_rst", 32'(bus.reset_o), 7);
    check("por_async_busy", 32'(bus.busy_o), 1);
    check("por_async_cause", 32'(bus.reset_cause_o), 0);
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    tick(7);  check("s1_edge7", 32'(bus.reset_o), 7);
    tick(1);  check("s1_edge8", 32'(bus.reset_o), 6);
    tick(3);  check("s1_edge11", 32'(bus.reset_o), 6);
    tick(1);  check("s1_edge12", 32'(bus.reset_o), 4);
    tick(3);  check("s1_edge15_busy", 32'(bus.busy_o), 1);
    tick(1);  check("s1_edge16", 32'(bus.reset_o), 0);
    check("s1_edge16_busy", 32'(bus.busy_o), 0);
    check("s1_cause", 32'(bus.reset_cause_o), 0);

    // 2. Short glitch ignored; long press resets, release re-sequences.
    bus.btn_i = 1'b0; tick(3);
    bus.btn_i = 1'b1; tick(10);
    check("s2_glitch", 32'(bus.reset_o), 0);
    bus.btn_i = 1'b0;
    tick(7);  check("s2_press_e7", 32'(bus.reset_o), 0);
    tick(1);  check("s2_press_e8", 32'(bus.reset_o), 7);
    check("s2_cause", 32'(bus.reset_cause_o), 1);
    tick(12);
    bus.btn_i = 1'b1;
    tick(14); check("s2_rel_e14", 32'(bus.reset_o), 7);
    tick(1);  check("s2_rel_e15", 32'(bus.reset_o), 6);
    tick(4);  check("s2_rel_e19", 32'(bus.reset_o), 4);
    tick(4);  check("s2_rel_e23", 32'(bus.reset_o), 0);

    // 3. Software pulse from RUN.
    sw_pulse();
    check("s3_assert", 32'(bus.reset_o), 7);
    check("s3_cause", 32'(bus.reset_cause_o), 2);
    tick(7);  check("s3_e7", 32'(bus.reset_o), 7);
    tick(1);  check("s3_e8", 32'(bus.reset_o), 6);
    tick(8);  check("s3_e16", 32'(bus.reset_o), 0);

    // 4. Software pulse mid-release restarts the whole sequence.
    sw_pulse();
    tick(8);  check("s4_first_rel", 32'(bus.reset_o), 6);
    sw_pulse();
    check("s4_reassert", 32'(bus.reset_o), 7);
    tick(7);  check("s4_e7", 32'(bus.reset_o), 7);
    tick(1);  check("s4_e8", 32'(bus.reset_o), 6);
    tick(8);  check("s4_done", 32'(bus.reset_o), 0);

    // 5. Button and software requests seen on the same edge: button wins.
    bus.btn_i = 1'b0;
    tick(7);
    sw_pulse();
    check("s5_assert", 32'(bus.reset_o), 7);
    check("s5_cause", 32'(bus.reset_cause_o), 1);
    bus.btn_i = 1'b1;
    tick(30); check("s5_done", 32'(bus.reset_o), 0);

    // 6. Hard reset between edges during release.
    sw_pulse();
    tick(12);
    check("s6_pre_rst", 32'(bus.reset_o), 4);
    check("s6_pre_cause", 32'(bus.reset_cause_o), 2);
    #2 reset_i = 1'b1;
    #1;
    check("s6_async_rst", 32'(bus.reset_o), 7);
    check("s6_async_cause", 32'(bus.reset_cause_o), 0);
    check("s6_async_busy", 32'(bus.busy_o), 1);
    @(negedge clk);
    tick(2);
    reset_i = 1'b0;
    tick(7);  check("s6_e7", 32'(bus.reset_o), 7);
    tick(1);  check("s6_e8", 32'(bus.reset_o), 6);
    tick(4);  check("s6_e12", 32'(bus.reset_o), 4);
    tick(4);  check("s6_e16", 32'(bus.reset_o), 0);
    check("s6_busy", 32'(bus.busy_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
